seq1010_frame_ctrl: RTL

Framed front-end controller for the non-overlapping "1010" sequence detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an internal Mealy 1010 detector. It counts detections across all words of a frame and reports the per-frame count on a second valid/ready handshake. It sits between a word-oriented producer and the bit-serial detection datapath and owns all sequencing, frame boundaries and detector-state clearing.

---
 rtl/seq1010_frame_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq1010_frame_ctrl.sv
// Framed 1010 detector front-end: accepts words over valid/ready, serializes
// them MSB-first into a non-overlapping Mealy 1010 detector, reports per-frame counts.
module seq1010_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              det_pulse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_hit,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high; out_valid/out_count/out_hit hold until that edge.

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} state_t;
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} det_t;

  state_t            state_q, state_d;
  det_t              det_q, det_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              bit_in;
  logic              match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      det_q    <= S0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      det_q    <= det_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    match     = 1'b0;
    bit_in    = shreg_q[DATA_W-1];

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d  = in_data;
          last_d   = in_last;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        case (det_q)
          S0: det_d = bit_in ? S1 : S0;
          S1: det_d = bit_in ? S1 : S2;
          S2: det_d = bit_in ? S3 : S0;
          S3: begin
            // Match restarts from S0 so no bits are shared between matches.
            det_d = bit_in ? S1 : S0;
            match = !bit_in;
          end
          default: det_d = S0;
        endcase
        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (match) begin
          pulse_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
        if (bitcnt_q == BW'(DATA_W - 1)) state_d = last_q ? REPORT : IDLE;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = '0;
          det_d   = S0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign det_pulse = pulse_q;
  assign out_count = cnt_q;
  assign out_hit   = |cnt_q;
  assign dbg_state = state_q;

endmodule
